seq_booth_multiplier: RTL

//   Parametrised sequential N x M multiplier, radix-2 Booth, one multiplier bit per clock.

---
 rtl/seq_booth_multiplier.sv | 96 +++++++++
 1 files changed

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - sequential radix-2 Booth N x M multiplier, signed or unsigned
// One multiplier bit retired per clock; operands are widened by one bit so both modes share the signed datapath.
module seq_booth_multiplier #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [N+M-1:0] P
);

  localparam int CW = $clog2(M + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N+1:0]   acc;
  logic [M:0]     bq;
  logic           bprev;
  logic [N:0]     a_ext;
  logic [CW-1:0]  cnt;

  logic [N+1:0]   a_wide;
  logic [N+1:0]   sum;
  logic [N+1:0]   acc_sh;
  logic [M:0]     bq_sh;

  // Booth recode of {b[i], b[i-1]} followed by the arithmetic shift of {acc, b}.
  always_comb begin
    a_wide = {a_ext[N], a_ext};
    sum    = acc;
    case ({bq[0], bprev})
      2'b01:   sum = acc + a_wide;
      2'b10:   sum = acc - a_wide;
      default: sum = acc;
    endcase
    acc_sh = {sum[N+1], sum[N+1:1]};
    bq_sh  = {sum[0], bq[M:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      bq    <= '0;
      bprev <= 1'b0;
      a_ext <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_ext <= is_signed ? {A[N-1], A} : {1'b0, A};
            bq    <= is_signed ? {B[M-1], B} : {1'b0, B};
            bprev <= 1'b0;
            acc   <= '0;
            cnt   <= CW'(M + 1);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_sh;
          bq    <= bq_sh;
          bprev <= bq[0];
          cnt   <= cnt - 1'b1;
          // Last step: the shifted {acc, b} already holds the full product.
          if (cnt == CW'(1)) begin
            P     <= {acc_sh[N-2:0], bq_sh};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
